// File: rtl/uart_receive_if.sv
// Peripheral bus bundle for the UART receiver: CPU-side register access.
interface uart_receive_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  write;
  logic                  read;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output addr, wdata, write, read, input rdata);
  modport slave  (input addr, wdata, write, read, output rdata);
endinterface

// File: rtl/uart_receive.sv
// UART 8N1 receiver with mid-bit sampling, small byte FIFO and RXDATA/STATUS registers.
//  state | meaning
//  IDLE  | waiting for a falling edge on synchronised rx
//  START | timing to mid start bit, confirm it is still low
//  DATA  | sampling 8 data bits, LSB first
//  STOP  | sampling stop bit, push byte or raise frame/overrun flag
module uart_receive #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_receive_if.slave  bus,
  input  logic           rx,
  output logic           irq
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CW-1:0]         HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]         FULL_TC = CW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RX = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ST = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_meta, rx_s, rx_prev;
  logic            stop_ok, stop_bad;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            empty, full, push, pop;
  logic            overrun, frame_err;
  logic            ov_clr, fe_clr;
  logic            unused_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Bit timer counts down from the terminal value; action happens when it reaches zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_d = START;
          cnt_d   = HALF_TC;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = FULL_TC;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL_TC;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d  = IDLE;
          stop_ok  = rx_s;
          stop_bad = !rx_s;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty = (count == '0);
  assign full  = (count == CNTW'(FIFO_DEPTH));
  assign pop   = bus.read && (bus.addr == ADDR_RX) && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push  = stop_ok && (!full || pop);
  assign irq   = !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNTW'(push) - CNTW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_q;
  end

  assign ov_clr       = bus.write && (bus.addr == ADDR_ST) && bus.wdata[3];
  assign fe_clr       = bus.write && (bus.addr == ADDR_ST) && bus.wdata[2];
  assign unused_wdata = ^{bus.wdata[DATA_WIDTH-1:4], bus.wdata[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (stop_ok && full && !pop) overrun <= 1'b1;
      else if (ov_clr)             overrun <= 1'b0;
      if (stop_bad)                frame_err <= 1'b1;
      else if (fe_clr)             frame_err <= 1'b0;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.addr == ADDR_RX) begin
      if (!empty) bus.rdata[7:0] = mem[rd_ptr];
    end else if (bus.addr == ADDR_ST) begin
      bus.rdata[3:0] = {overrun, frame_err, full, !empty};
    end
  end
endmodule

// File: tb/tb_uart_receive.sv
// Self-checking bench for uart_receive: directed scenarios plus random traffic against a queue model.
module tb_uart_receive;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic irq;

  uart_receive_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  uart_receive #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .rx(rx), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  logic       m_ov = 1'b0;
  logic       m_fe = 1'b0;

  function automatic logic [31:0] model_status();
    return {28'd0, m_ov, m_fe, (mq.size() == DEPTH), (mq.size() != 0)};
  endfunction

  function automatic void model_frame(logic [7:0] b, logic stop);
    if (!stop)                  m_fe = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(b);
    else                        m_ov = 1'b1;
  endfunction

  function automatic logic [31:0] model_pop();
    if (mq.size() == 0) return 32'd0;
    return {24'd0, mq.pop_front()};
  endfunction

  function automatic void model_w1c(logic [31:0] wd);
    if (wd[3]) m_ov = 1'b0;
    if (wd[2]) m_fe = 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk); #1 rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = stop;
    repeat (CPB) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.addr = a;
    bus.read = 1'b1;
    #1 d = bus.rdata;
    @(posedge clk);
    #1 bus.read = 1'b0;
    bus.addr = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr  = a;
    bus.wdata = d;
    bus.write = 1'b1;
    @(posedge clk);
    #1 bus.write = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    bus_read(32'h4, d);
    check(tag, d, model_status());
    check({tag, "_irq"}, {31'd0, irq}, {31'd0, mq.size() != 0});
  endtask

  task automatic chk_pop(input string tag);
    logic [31:0] d, e;
    e = model_pop();
    bus_read(32'h0, d);
    check(tag, d, e);
  endtask

  // Runs a frame and, in the cycle whose closing edge samples the stop bit
  // (edge 155 after the start bit is driven: 2 sync + 1 detect + 8 half-bit + 9*16),
  // issues either an RXDATA read (op=0) or a STATUS write of wd (op=1).
  task automatic frame_with_op(input logic [7:0] b, input logic stop, input bit op,
                               input logic [31:0] wd, output logic [31:0] rd);
    rd = '0;
    fork
      send_frame(b, stop);
      begin
        @(negedge rx);
        repeat (154) @(posedge clk);
        #2;
        if (op == 1'b0) begin
          bus.addr = 32'h0;
          bus.read = 1'b1;
          #1 rd = bus.rdata;
        end else begin
          bus.addr  = 32'h4;
          bus.wdata = wd;
          bus.write = 1'b1;
        end
        @(posedge clk);
        #1 bus.read = 1'b0;
        bus.write = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
      end
    join
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d, e;
    logic [7:0]  b;
    logic        s;
    int          r;

    bus.addr = '0; bus.wdata = '0; bus.write = 1'b0; bus.read = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #2 check("rst_rxdata", bus.rdata, 32'd0);
    bus.addr = 32'h4;
    #1 check("rst_status", bus.rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    bus.addr = '0;
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);

    // 1: single frame
    send_frame(8'hA5, 1'b1); model_frame(8'hA5, 1'b1);
    chk_status("t1_status_full");
    chk_pop("t1_rxdata");
    chk_status("t1_status_empty");

    // 2: start glitch, then a clean frame
    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk); #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    chk_status("t2_glitch_status");
    send_frame(8'h3C, 1'b1); model_frame(8'h3C, 1'b1);
    chk_status("t2_status");
    chk_pop("t2_rxdata");

    // 3: framing error then W1C
    send_frame(8'h3C, 1'b0); model_frame(8'h3C, 1'b0);
    chk_status("t3_frame_err");
    bus_write(32'h4, 32'h3); model_w1c(32'h3);
    chk_status("t3_w1c_other_bits");
    bus_write(32'h4, 32'h4); model_w1c(32'h4);
    chk_status("t3_cleared");

    // 4: overflow
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1); model_frame(8'(i), 1'b1);
    end
    chk_status("t4_overrun_full");
    for (int i = 0; i < 4; i++) chk_pop("t4_rxdata");
    chk_status("t4_after_drain");
    chk_pop("t4_pop_empty");
    bus_write(32'h4, 32'h8); model_w1c(32'h8);
    chk_status("t4_cleared");

    // 5: push and pop in the same cycle while full
    foreach (mq[i]) ; // queue is empty here
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i * 17), 1'b1); model_frame(8'(i * 17), 1'b1);
    end
    chk_status("t5_full");
    frame_with_op(8'h77, 1'b1, 1'b0, 32'h0, d);
    e = model_pop(); model_frame(8'h77, 1'b1);
    check("t5_concurrent_pop", d, e);
    chk_status("t5_no_overrun");
    for (int i = 0; i < 4; i++) chk_pop("t5_rxdata");
    chk_status("t5_empty");

    // Set beats W1C in the same cycle
    frame_with_op(8'h10, 1'b0, 1'b1, 32'h4, d);
    model_w1c(32'h4); model_frame(8'h10, 1'b0);
    chk_status("set_wins");
    bus_write(32'h4, 32'hC); model_w1c(32'hC);

    // Unmapped address reads zero; writes to RXDATA do nothing
    send_frame(8'h66, 1'b1); model_frame(8'h66, 1'b1);
    bus_read(32'h8, d);
    check("unmapped_read", d, 32'd0);
    bus_write(32'h0, 32'hFF);
    chk_status("status_after_bad_write");
    chk_pop("rxdata_66");

    // 6: reset mid-frame
    send_frame(8'h42, 1'b1); model_frame(8'h42, 1'b1);
    send_frame(8'h99, 1'b0); model_frame(8'h99, 1'b0);
    chk_status("t6_pre");
    fork
      send_frame(8'hF8, 1'b1);
      begin
        @(negedge rx);
        repeat (CPB * 4 + 8) @(posedge clk);
        #3 rst = 1'b1;
        bus.addr = 32'h4;
        #1 check("t6_status_in_rst", bus.rdata, 32'd0);
        check("t6_irq_in_rst", {31'd0, irq}, 32'd0);
        bus.addr = '0;
        #3 rst = 1'b0;
      end
    join
    mq.delete(); m_ov = 1'b0; m_fe = 1'b0;
    repeat (20) @(posedge clk);
    chk_status("t6_after_rst");
    send_frame(8'h5A, 1'b1); model_frame(8'h5A, 1'b1);
    chk_pop("t6_rxdata");
    chk_status("t6_final");

    // Random traffic
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        b = 8'($urandom);
        s = ($urandom_range(0, 6) != 0);
        send_frame(b, s); model_frame(b, s);
      end else if (r < 8) begin
        chk_pop("rnd_rxdata");
      end else begin
        d = {28'd0, 4'($urandom)};
        bus_write(32'h4, d); model_w1c(d);
      end
      repeat ($urandom_range(0, 12)) @(posedge clk);
      chk_status("rnd_status");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
